// File: rtl/result_display_pkg.sv
// Shared definitions for the result display path: converter states, display
// symbol codes, the symbol-to-segment table and the double-dabble adjust step.
package result_display_pkg;

    localparam int DATA_W      = 20;
    localparam int BCD_DIGITS  = 7;
    localparam int BCD_W       = 4 * BCD_DIGITS;
    localparam int DISP_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef logic [3:0] sym_t;

    // Codes 0..9 are the decimal digits themselves.
    localparam sym_t SYM_ZERO  = 4'd0;
    localparam sym_t SYM_MINUS = 4'd10;
    localparam sym_t SYM_BLANK = 4'd15;

    // Active-low {g,f,e,d,c,b,a}; index 15 first in the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, // 15..11
        7'b0111111,                                                 // 10 '-'
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010, // 9..5
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000  // 4..0
    };

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational symbol code to active-low 7-segment pattern.
module seg7_decoder
    import result_display_pkg::*;
(
    input  logic [3:0] sym,
    output logic [6:0] seg
);

    // Table lookup; unused codes map to blank.
    always_comb begin
        seg = SEG_TABLE[sym];
    end

endmodule

// File: rtl/result_display.sv
// Converts the 20-bit result to BCD by sequential double-dabble and drives the
// 4-digit multiplexed display with blanking, sign and overflow indication.
module result_display
    import result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 6250,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
    input  logic              neg,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [BCD_W-1:0]  bcd,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [4:0]       LAST_BIT = 5'(DATA_W - 1);

    state_t            state_r, next_state_s;
    logic [DATA_W-1:0] shift_r, shift_step_s;
    logic [BCD_W-1:0]  acc_r, adj_s, acc_step_s, bcd_r;
    logic [4:0]        bit_cnt_r;
    logic              neg_r, busy_r, done_r, overflow_r;
    logic              last_step_s, ovf_next_s;
    logic [1:0]        msd_s;
    sym_t              disp_r      [DISP_DIGITS];
    sym_t              disp_next_s [DISP_DIGITS];
    logic [CNT_W-1:0]  refresh_cnt_r;
    logic [1:0]        scan_idx_r;
    sym_t              cur_sym_s;
    logic [6:0]        cur_seg_s, seg_r;
    logic [3:0]        an_r;

    // Converter next-state logic; flags the final shift step.
    always_comb begin
        next_state_s = state_r;
        last_step_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) next_state_s = ST_SHIFT;
                else      next_state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (bit_cnt_r == LAST_BIT) begin
                    next_state_s = ST_FINISH;
                    last_step_s  = 1'b1;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_FINISH: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // One double-dabble step: adjust nibbles, then shift {acc, shift} left.
    always_comb begin
        adj_s        = dabble_adjust(acc_r);
        acc_step_s   = {adj_s[BCD_W-2:0], shift_r[DATA_W-1]};
        shift_step_s = {shift_r[DATA_W-2:0], 1'b0};
    end

    // Display formatting of the completed value: overflow, sign, blanking.
    always_comb begin
        ovf_next_s = (|acc_step_s[BCD_W-1:16]) | (neg_r & (|acc_step_s[15:12]));
        msd_s      = 2'd0;
        for (int i = 1; i < DISP_DIGITS; i++) begin
            if (acc_step_s[4*i +: 4] != 4'd0) msd_s = 2'(i);
            else                              msd_s = msd_s;
        end
        for (int i = 0; i < DISP_DIGITS; i++) begin
            if (ovf_next_s) begin
                disp_next_s[i] = SYM_MINUS;
            end else if ((i == int'(msd_s) + 1) && neg_r && (acc_step_s[15:0] != 16'd0)) begin
                disp_next_s[i] = SYM_MINUS;
            end else if ((i > int'(msd_s)) && BLANK_ZEROS) begin
                disp_next_s[i] = SYM_BLANK;
            end else begin
                disp_next_s[i] = acc_step_s[4*i +: 4];
            end
        end
    end

    // Converter state, datapath and atomic update of the result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_W{1'b0}};
            acc_r      <= {BCD_W{1'b0}};
            bit_cnt_r  <= 5'd0;
            neg_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            bcd_r      <= {BCD_W{1'b0}};
            disp_r[0]  <= SYM_ZERO;
            for (int i = 1; i < DISP_DIGITS; i++) disp_r[i] <= SYM_BLANK;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_SHIFT);
            done_r  <= (next_state_s == ST_FINISH);
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        shift_r   <= value;
                        neg_r     <= neg;
                        acc_r     <= {BCD_W{1'b0}};
                        bit_cnt_r <= 5'd0;
                    end
                end
                ST_SHIFT: begin
                    acc_r     <= acc_step_s;
                    shift_r   <= shift_step_s;
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                    if (last_step_s) begin
                        bcd_r      <= acc_step_s;
                        overflow_r <= ovf_next_s;
                        for (int i = 0; i < DISP_DIGITS; i++) disp_r[i] <= disp_next_s[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slot timer and scan index, free-running regardless of conversions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
            scan_idx_r    <= 2'd0;
        end else if (refresh_cnt_r == CNT_LAST) begin
            refresh_cnt_r <= {CNT_W{1'b0}};
            scan_idx_r    <= scan_idx_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
        end
    end

    assign cur_sym_s = disp_r[scan_idx_r];

    seg7_decoder u_dec (
        .sym (cur_sym_s),
        .seg (cur_seg_s)
    );

    // Glitch-free anode/segment outputs, one cycle behind the scan index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_r  <= 4'b1110;
            seg_r <= 7'b1000000;
        end else begin
            an_r  <= ~(4'b0001 << scan_idx_r);
            seg_r <= cur_seg_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign bcd      = bcd_r;
    assign an       = an_r;
    assign seg      = seg_r;
    assign dp       = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: one instance with blanking, one without.
module tb_result_display;

    localparam int DIV = 8;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;

    logic        clk, reset_n, load, neg;
    logic [19:0] value;
    logic        busy, done, overflow, dp, busy0, done0, overflow0, dp0;
    logic [27:0] bcd, bcd0;
    logic [3:0]  an, an0;
    logic [6:0]  seg, seg0;
    logic [6:0]  cap [4];
    logic [6:0]  cap0 [4];
    int checks = 0, passes = 0, fails = 0;

    result_display #(.REFRESH_DIV(DIV), .BLANK_ZEROS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .value(value), .neg(neg),
        .busy(busy), .done(done), .overflow(overflow), .bcd(bcd),
        .an(an), .seg(seg), .dp(dp));

    result_display #(.REFRESH_DIV(DIV), .BLANK_ZEROS(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .load(load), .value(value), .neg(neg),
        .busy(busy0), .done(done0), .overflow(overflow0), .bcd(bcd0),
        .an(an0), .seg(seg0), .dp(dp0));

    always #5 clk = ~clk;

    function automatic logic [6:0] dg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic [19:0] v, input logic n);
        @(negedge clk);
        load = 1'b1; value = v; neg = n;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Samples busy/done of both instances for 30 cycles after a load.
    task automatic watch(input string tag);
        int bc = 0, dc = 0, da = 0, bc0 = 0, dc0 = 0;
        for (int i = 1; i <= 30; i++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin dc++; if (da == 0) da = i; end
            if (busy0 === 1'b1) bc0++;
            if (done0 === 1'b1) dc0++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, bc, 32'd20);
        chk({tag, " done_cycle"}, da, 32'd21);
        chk({tag, " done_count"}, dc, 32'd1);
        chk({tag, " busy0_cycles"}, bc0, 32'd20);
        chk({tag, " done0_count"}, dc0, 32'd1);
    endtask

    // Records the segment pattern seen in each anode slot over a full scan.
    task automatic capture();
        logic [3:0] sel;
        for (int k = 0; k < 4; k++) begin cap[k] = 7'bx; cap0[k] = 7'bx; end
        for (int c = 0; c < 4 * DIV + 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                sel = 4'b0001 << k;
                if (an === ~sel) cap[k] = seg;
                if (an0 === ~sel) cap0[k] = seg0;
            end
        end
    endtask

    task automatic chk_disp(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                            input logic [6:0] d1, input logic [6:0] d0);
        chk({tag, " digit3"}, {25'd0, cap[3]}, {25'd0, d3});
        chk({tag, " digit2"}, {25'd0, cap[2]}, {25'd0, d2});
        chk({tag, " digit1"}, {25'd0, cap[1]}, {25'd0, d1});
        chk({tag, " digit0"}, {25'd0, cap[0]}, {25'd0, d0});
    endtask

    task automatic conv(input string tag, input logic [19:0] v, input logic n,
                        input logic [27:0] eb, input logic eo,
                        input logic [6:0] d3, input logic [6:0] d2,
                        input logic [6:0] d1, input logic [6:0] d0);
        run_load(v, n);
        watch(tag);
        chk({tag, " bcd"}, {4'd0, bcd}, {4'd0, eb});
        chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
        capture();
        chk_disp(tag, d3, d2, d1, d0);
    endtask

    initial begin
        int n;
        clk = 1'b0; reset_n = 1'b0; load = 1'b0; value = 20'd0; neg = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state and slot timing
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst overflow", {31'd0, overflow}, 32'd0);
        chk("rst bcd", {4'd0, bcd}, 32'd0);
        chk("rst an", {28'd0, an}, 32'b1110);
        chk("rst seg", {25'd0, seg}, {25'd0, 7'b1000000});
        chk("dp", {31'd0, dp}, 32'd1);
        n = 0;
        while (an === 4'b1110 && n < 50) begin n++; @(negedge clk); end
        chk("first slot cycles", n, 32'd9);
        chk("second anode", {28'd0, an}, 32'b1101);
        n = 0;
        while (an === 4'b1101 && n < 50) begin n++; @(negedge clk); end
        chk("slot length", n, DIV);
        chk("third anode", {28'd0, an}, 32'b1011);
        capture();
        chk_disp("rst", BL, BL, BL, dg(0));

        conv("v1234", 20'd1234, 1'b0, 28'h0001234, 1'b0, dg(1), dg(2), dg(3), dg(4));

        conv("v7", 20'd7, 1'b0, 28'h0000007, 1'b0, BL, BL, BL, dg(7));
        chk("v7 noblank digit3", {25'd0, cap0[3]}, {25'd0, dg(0)});
        chk("v7 noblank digit2", {25'd0, cap0[2]}, {25'd0, dg(0)});
        chk("v7 noblank digit1", {25'd0, cap0[1]}, {25'd0, dg(0)});
        chk("v7 noblank digit0", {25'd0, cap0[0]}, {25'd0, dg(7)});
        chk("v7 noblank overflow", {31'd0, overflow0}, 32'd0);
        chk("v7 noblank bcd", {4'd0, bcd0}, 32'h0000007);
        chk("dp0", {31'd0, dp0}, 32'd1);

        conv("neg42", 20'd42, 1'b1, 28'h0000042, 1'b0, BL, MI, dg(4), dg(2));
        conv("neg999", 20'd999, 1'b1, 28'h0000999, 1'b0, MI, dg(9), dg(9), dg(9));
        conv("neg1000", 20'd1000, 1'b1, 28'h0001000, 1'b1, MI, MI, MI, MI);
        conv("v9999", 20'd9999, 1'b0, 28'h0009999, 1'b0, dg(9), dg(9), dg(9), dg(9));
        conv("vmax", 20'd1048575, 1'b0, 28'h1048575, 1'b1, MI, MI, MI, MI);
        conv("neg0", 20'd0, 1'b1, 28'h0000000, 1'b0, BL, BL, BL, dg(0));

        // Load during a conversion is ignored
        run_load(20'd500, 1'b0);
        repeat (4) @(negedge clk);
        load = 1'b1; value = 20'd99;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) n++;
            @(negedge clk);
        end
        chk("ignored load done_count", n, 32'd1);
        chk("ignored load bcd", {4'd0, bcd}, 32'h0000500);
        capture();
        chk_disp("ignored load", BL, dg(5), dg(0), dg(0));

        // Reset in the middle of a conversion
        run_load(20'd8888, 1'b0);
        repeat (9) @(negedge clk);
        chk("pre-abort busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || busy === 1'b1) n++;
            @(negedge clk);
        end
        chk("abort no activity", n, 32'd0);
        chk("abort bcd", {4'd0, bcd}, 32'd0);
        capture();
        chk_disp("abort", BL, BL, BL, dg(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
Consumes the calculator result word and renders it on the 4-digit multiplexed 7-segment display, the output end of the calculator datapath.
Uses a load/busy/done handshake to convert the 20-bit binary result to 7 BCD digits by sequential double-dabble, one bit per clock.
Drives an active-low anode scan, with leading-zero blanking, a minus sign and overflow indication.
Display registers update atomically on conversion completion, so the display never shows a partial value.

Parameters:
REFRESH_DIV, 6250, clk cycles per digit slot (6.25 MHz clock gives a 1 kHz slot rate).
BLANK_ZEROS, 1, 1 = blank leading zeros; 0 = show all four digits.

Ports:
clk  in  1  system clock (slow_clk domain)
reset_n  in  1  asynchronous, active-low reset
load  in  1  single-cycle request to convert value/neg
value  in  20  unsigned magnitude to display
neg  in  1  magnitude is negative
busy  out  1  conversion in progress
done  out  1  one-cycle pulse: conversion finished, display updated
overflow  out  1  latched: last result not representable on 4 digits
bcd  out  28  7 BCD digits of last converted value, digit 0 in [3:0]
an  out  4  anode enables, active-low, an[0] = rightmost digit
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, constant 1 (off)

Behaviour:
- Reset (async assert, sync release) sets:
  - busy=0, done=0, overflow=0, bcd=0.
  - Display shows "   0"; scan index 0; an=4'b1110; refresh counter 0.
- FSM has states IDLE, SHIFT, FINISH.
- IDLE:
  - load=1 latches value into shift register and neg into sign register.
  - Clears the BCD accumulator and bit counter, then goes to SHIFT; busy=1 from the next cycle.
- SHIFT, 20 cycles:
  - Each cycle, every BCD nibble >=5 gets +3.
  - Then {bcd_acc, shift} shifts left 1; the value MSB enters bcd_acc[0].
  - Bit counter 0..19; when counter=19, go to FINISH.
- FINISH, one cycle:
  - done=1, busy=0.
  - bcd, overflow and the 4 display digit registers are written.
  - Return to IDLE.
- Latency: load sampled at edge N gives busy high edges N+1..N+20 and done high after edge N+21.
- load while busy or in FINISH is ignored; no queueing.
- overflow=1 in either case below; the display then shows "----":
  - value > 9999;
  - neg=1 and value > 999.
- Sign handling:
  - neg=1 with value=0 shows "   0" with no sign.
  - Otherwise the sign digit '-' goes immediately left of the most significant non-zero digit.
- Leading-zero blanking (BLANK_ZEROS=1): digits above the MSD are blank; digit 0 is never blanked.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1; on wrap, scan index goes 0,1,2,3,0.
  - an = ~(1 << index); seg shows the display register for that index.
  - Scan runs continuously, independent of conversion.
- Encodings:
  - '0'..'9' use standard active-low patterns ('0' = 7'b1000000, '1' = 7'b1111001).
  - '-' = 7'b0111111; blank = 7'b1111111.
- Reset mid-conversion aborts: FSM goes to IDLE, no done pulse, display returns to "   0".

Decomposition:
- Shared package result_display_pkg holds:
  - state encodings;
  - display-symbol codes (0-9, SYM_MINUS, SYM_BLANK);
  - the symbol-to-segment constant table;
  - DATA_W=20 and BCD_DIGITS=7.
- One sub-module, seg7_decoder: a combinational 4-bit symbol code to 7-bit active-low segment pattern, shared with other display users.
- The converter FSM and scan counter stay in result_display.

Test Plan:
- Reset only → an=1110, seg=1000000; at each slot wrap, an=1101/1011/0111 with seg=1111111.
- load with value=1234, neg=0 →
  - busy high exactly 20 cycles, done pulse on cycle 21;
  - bcd=28'h0001234;
  - scan shows 4,3,2,1 on an[0..3].
- value=7, BLANK_ZEROS=1 → "   7"; the same value with BLANK_ZEROS=0 → "0007"; overflow=0.
- neg=1 and value=42 → " -42".
- Overflow cases:
  - neg=1, value=1000 → overflow=1, "----".
  - value=1048575 → bcd=28'h1048575, overflow=1.
- Pulse load again 5 cycles into a conversion with value=99 → ignored, first result displayed.
- Assert reset_n=0 at cycle 10 of a conversion → busy=0 at once, no done pulse, display "   0".
